// File: rtl/sprite_move_ctrl.sv
// Sprite offset controller: debounced buttons step the sprite once per frame,
// with wrap-around on manual moves and edge-bouncing when auto mode is enabled.
module sprite_move_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int STEP_POS   = 2,
  parameter int STEP_NEG   = 1,
  parameter int AUTO_STEP  = 1,
  parameter int RECT_W     = 50,
  parameter int RECT_H     = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        frame_tick,
  input  logic        move_x_poz,
  input  logic        move_x_neg,
  input  logic        move_y_poz,
  input  logic        move_y_neg,
  input  logic        auto_en,
  output logic [10:0] x_off,
  output logic [10:0] y_off,
  output logic        upd
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [3:0]    btn_s;
  logic [3:0]    sync1_r;
  logic [3:0]    sync2_r;
  logic [CW-1:0] cnt_r [4];
  logic [3:0]    press_s;
  logic [3:0]    press_r;
  logic          auto_r;
  logic          mode_r;
  logic          dx_neg_r;
  logic          dy_neg_r;
  logic [10:0]   x_r;
  logic [10:0]   y_r;
  logic          upd_r;
  logic [11:0]   xmax_s;
  logic [11:0]   ymax_s;
  logic [11:0]   xcur_s;
  logic [11:0]   ycur_s;
  logic [12:0]   xnext_s;
  logic [12:0]   ynext_s;

  // One axis step; returns {new direction-negative flag, new offset}.
  function automatic logic [12:0] axis_next(
    input logic [11:0] cur,
    input logic [11:0] lim,
    input logic        poz,
    input logic        neg,
    input logic        au,
    input logic        dneg
  );
    logic [11:0] off;
    logic        d;
    off = cur;
    d   = dneg;
    if (poz) begin
      if (cur + 12'(STEP_POS) > lim) begin
        off = 12'd0;
      end else begin
        off = cur + 12'(STEP_POS);
      end
    end else if (neg) begin
      if (cur < 12'(STEP_NEG)) begin
        off = lim;
      end else begin
        off = cur - 12'(STEP_NEG);
      end
    end else if (au) begin
      if (!dneg) begin
        if (cur + 12'(AUTO_STEP) >= lim) begin
          off = lim;
          d   = 1'b1;
        end else begin
          off = cur + 12'(AUTO_STEP);
        end
      end else begin
        if (cur <= 12'(AUTO_STEP)) begin
          off = 12'd0;
          d   = 1'b0;
        end else begin
          off = cur - 12'(AUTO_STEP);
        end
      end
    end else begin
      off = cur;
      d   = dneg;
    end
    return {d, off};
  endfunction

  assign btn_s = {move_y_neg, move_y_poz, move_x_neg, move_x_poz};

  // Two-flop synchronizers for the raw buttons (idle level is high).
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r <= 4'hF;
      sync2_r <= 4'hF;
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
    end
  end

  // Saturating debounce counters, cleared whenever the level is released.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst) begin
        cnt_r[i] <= '0;
      end else if (sync2_r[i]) begin
        cnt_r[i] <= '0;
      end else if (cnt_r[i] != CW'(DEB_CYCLES)) begin
        cnt_r[i] <= cnt_r[i] + CW'(1);
      end else begin
        cnt_r[i] <= cnt_r[i];
      end
    end
  end

  // Press flags.
  always_comb begin
    press_s = 4'd0;
    for (int i = 0; i < 4; i++) begin
      press_s[i] = (cnt_r[i] == CW'(DEB_CYCLES));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; ticks outside IDLE are dropped.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = frame_tick ? EVAL : IDLE;
      EVAL:    state_s = APPLY;
      APPLY:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Mode is only resampled while idle so limits stay stable during an update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_r  <= mode;
      press_r <= 4'd0;
      auto_r  <= 1'b0;
    end else begin
      mode_r  <= (state_r == IDLE) ? mode : mode_r;
      if (state_r == EVAL) begin
        press_r <= press_s;
        auto_r  <= auto_en;
      end else begin
        press_r <= press_r;
        auto_r  <= auto_r;
      end
    end
  end

  // Limits, clamp-to-limit after a mode shrink, then the per-axis move.
  always_comb begin
    xmax_s  = mode_r ? 12'(800 - RECT_W) : 12'(640 - RECT_W);
    ymax_s  = mode_r ? 12'(600 - RECT_H) : 12'(480 - RECT_H);
    xcur_s  = ({1'b0, x_r} > xmax_s) ? xmax_s : {1'b0, x_r};
    ycur_s  = ({1'b0, y_r} > ymax_s) ? ymax_s : {1'b0, y_r};
    xnext_s = axis_next(xcur_s, xmax_s, press_r[0], press_r[1], auto_r, dx_neg_r);
    ynext_s = axis_next(ycur_s, ymax_s, press_r[2], press_r[3], auto_r, dy_neg_r);
  end

  // Offset, direction and update-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_r      <= 11'd0;
      y_r      <= 11'd0;
      dx_neg_r <= 1'b0;
      dy_neg_r <= 1'b0;
      upd_r    <= 1'b0;
    end else if (state_r == APPLY) begin
      x_r      <= xnext_s[10:0];
      y_r      <= ynext_s[10:0];
      dx_neg_r <= xnext_s[12];
      dy_neg_r <= ynext_s[12];
      upd_r    <= 1'b1;
    end else begin
      x_r      <= x_r;
      y_r      <= y_r;
      dx_neg_r <= dx_neg_r;
      dy_neg_r <= dy_neg_r;
      upd_r    <= 1'b0;
    end
  end

  assign x_off = x_r;
  assign y_off = y_r;
  assign upd   = upd_r;

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Self-checking bench for sprite_move_ctrl with an integer reference model.
module tb_sprite_move_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode = 1'b0;
  logic        frame_tick = 1'b0;
  logic        move_x_poz = 1'b1;
  logic        move_x_neg = 1'b1;
  logic        move_y_poz = 1'b1;
  logic        move_y_neg = 1'b1;
  logic        auto_en = 1'b0;
  logic [10:0] x_off;
  logic [10:0] y_off;
  logic        upd;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: offsets and bounce directions (+1 / -1).
  int m_x = 0;
  int m_y = 0;
  int m_dx = 1;
  int m_dy = 1;

  sprite_move_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .frame_tick (frame_tick),
    .move_x_poz (move_x_poz),
    .move_x_neg (move_x_neg),
    .move_y_poz (move_y_poz),
    .move_y_neg (move_y_neg),
    .auto_en    (auto_en),
    .x_off      (x_off),
    .y_off      (y_off),
    .upd        (upd)
  );

  always #5 clk = ~clk;

  task automatic model_axis(input int off, input int dir, input int lim,
                            input bit p, input bit n, input bit au,
                            output int o, output int d);
    int cur;
    cur = (off > lim) ? lim : off;
    d = dir;
    if (p)       o = (cur + 2 > lim) ? 0 : cur + 2;
    else if (n)  o = (cur < 1) ? lim : cur - 1;
    else if (au) begin
      o = cur + dir;
      if (o >= lim) begin o = lim; d = -1; end
      else if (o <= 0) begin o = 0; d = 1; end
    end
    else o = cur;
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 1; m_dy = 1;
  endtask

  task automatic set_buttons(input bit xp, input bit xn, input bit yp, input bit yn, input bit au);
    @(negedge clk);
    move_x_poz = ~xp; move_x_neg = ~xn; move_y_poz = ~yp; move_y_neg = ~yn;
    auto_en = au;
    repeat (25) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame: tick, confirm upd timing and the model's offsets.
  task automatic run_frame(input string name);
    int nx, ny, ndx, ndy, xl, yl;
    xl = mode ? 750 : 590;
    yl = mode ? 550 : 430;
    model_axis(m_x, m_dx, xl, !move_x_poz, !move_x_neg, auto_en, nx, ndx);
    model_axis(m_y, m_dy, yl, !move_y_poz, !move_y_neg, auto_en, ny, ndy);
    frame_tick = 1'b1;
    @(posedge clk); @(negedge clk);
    frame_tick = 1'b0;
    n_cmp++;
    if (upd !== 1'b0) begin n_fail++; $display("FAIL %s upd_t+0: got %0b expected 0", name, upd); end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (upd !== 1'b0) begin n_fail++; $display("FAIL %s upd_t+1: got %0b expected 0", name, upd); end
    @(posedge clk); @(negedge clk);
    m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
    n_cmp++;
    if (upd !== 1'b1) begin n_fail++; $display("FAIL %s upd_t+2: got %0b expected 1", name, upd); end
    n_cmp++;
    if (x_off !== 11'(m_x)) begin n_fail++; $display("FAIL %s x_off: got %0d expected %0d", name, x_off, m_x); end
    n_cmp++;
    if (y_off !== 11'(m_y)) begin n_fail++; $display("FAIL %s y_off: got %0d expected %0d", name, y_off, m_y); end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (upd !== 1'b0) begin n_fail++; $display("FAIL %s upd_t+3: got %0b expected 0", name, upd); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_x", int'(x_off), 0);
    check("reset_y", int'(y_off), 0);
    check("reset_upd", int'(upd), 0);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_basic_move();
    set_buttons(1, 0, 0, 0, 0);
    run_frame("basic_poz");
    check("basic_x_is_2", int'(x_off), 2);
    check("basic_y_is_0", int'(y_off), 0);
  endtask

  task automatic test_glitch();
    set_buttons(0, 0, 0, 0, 0);
    move_x_neg = 1'b0;
    repeat (10) @(negedge clk);
    move_x_neg = 1'b1;
    repeat (5) @(negedge clk);
    run_frame("glitch");
  endtask

  task automatic test_wrap();
    set_buttons(0, 1, 0, 0, 0);
    repeat (3) run_frame("wrap_neg");
    check("wrap_x_590", int'(x_off), 590);
    set_buttons(1, 0, 0, 0, 0);
    run_frame("wrap_poz");
    check("wrap_x_0", int'(x_off), 0);
    set_buttons(0, 1, 0, 0, 0);
    run_frame("wrap_neg_low");
    check("wrap_x_590b", int'(x_off), 590);
  endtask

  task automatic test_bounce();
    set_buttons(0, 0, 0, 1, 0);
    repeat (2) run_frame("bounce_setup");
    set_buttons(0, 0, 0, 0, 1);
    run_frame("bounce_1");
    check("bounce_y_430", int'(y_off), 430);
    run_frame("bounce_2");
    check("bounce_y_429", int'(y_off), 429);
    run_frame("bounce_3");
    check("bounce_y_428", int'(y_off), 428);
  endtask

  task automatic test_mode_change();
    @(negedge clk);
    mode = 1'b1; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    set_buttons(0, 1, 0, 0, 0);
    run_frame("mode_hi_neg");
    check("mode_x_750", int'(x_off), 750);
    mode = 1'b0;
    set_buttons(0, 0, 0, 0, 0);
    run_frame("mode_clamp");
    check("mode_x_590", int'(x_off), 590);
    set_buttons(1, 1, 0, 0, 0);
    run_frame("mode_both");
    check("mode_x_0", int'(x_off), 0);
  endtask

  task automatic test_reset_abort();
    set_buttons(1, 0, 0, 0, 0);
    run_frame("abort_setup");
    frame_tick = 1'b1;
    @(posedge clk); @(negedge clk);
    frame_tick = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      check("abort_upd", int'(upd), 0);
      check("abort_x", int'(x_off), 0);
      @(negedge clk);
    end
    set_buttons(1, 0, 0, 0, 0);
    run_frame("abort_resume");
    check("abort_resume_x", int'(x_off), 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      mode = ($urandom_range(0, 3) == 0) ? ~mode : mode;
      set_buttons($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1);
      run_frame("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_glitch();
    test_wrap();
    test_bounce();
    test_mode_change();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_move_ctrl.md
SPRITE_MOVE_CTRL -- requirements
Module: sprite_move_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16, meaning consecutive synchronized-low cycles before a button counts as pressed.
REQ-002 SHALL have parameter STEP_POS, default 2, meaning pixels added per frame for a right/up move.
REQ-003 SHALL have parameter STEP_NEG, default 1, meaning pixels subtracted per frame for a left/down move.
REQ-004 SHALL have parameter AUTO_STEP, default 1, meaning pixels per frame in bounce mode.
REQ-005 SHALL have parameters RECT_W and RECT_H, default 50 each, meaning sprite size used for limits.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, meaning the synchronous active-low reset.
REQ-008 SHALL have port mode, input, 1, meaning the resolution select: 0 = 640x480, 1 = 800x600.
REQ-009 SHALL have port frame_tick, input, 1, meaning a one-cycle pulse from the sync generator at start of vertical blanking.
REQ-010 SHALL have ports move_x_poz, move_x_neg, move_y_poz and move_y_neg, input, 1 each, meaning raw active-low buttons.
REQ-011 SHALL have port auto_en, input, 1, meaning 1 enables bounce mode when no button is pressed.
REQ-012 SHALL have ports x_off and y_off, output, 11 each, meaning the sprite offsets consumed by the pixel datapath.
REQ-013 SHALL have port upd, output, 1, meaning a one-cycle pulse in the cycle the offsets change.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a per-button saturating debounce counter.
REQ-015 Debounce counters: reset to 0 when the synchronized level is high; press flag = 1 when count reaches DEB_CYCLES.
REQ-016 Limits, from registered mode_q: XMAX = 640-RECT_W (590) or 800-RECT_W (750); YMAX = 480-RECT_H (430) or 600-RECT_H (550).
REQ-017 The FSM SHALL have states IDLE, EVAL and APPLY; it moves IDLE->EVAL on frame_tick, EVAL->APPLY unconditionally, and APPLY->IDLE unconditionally.
REQ-018 mode_q SHALL load mode only in IDLE.
REQ-019 frame_tick arriving in EVAL or APPLY SHALL be ignored.
REQ-020 EVAL SHALL latch the four press flags and auto_en.
REQ-021 APPLY SHALL write the new offsets and assert upd for exactly that cycle, i.e. 2 cycles after frame_tick.
REQ-022 upd SHALL pulse in APPLY even when the offsets do not change.
REQ-023 X axis, poz pressed: if x_off+STEP_POS > XMAX then x_off <= 0, else x_off <= x_off+STEP_POS.
REQ-024 X axis, neg pressed (poz not pressed): if x_off < STEP_NEG then x_off <= XMAX, else x_off <= x_off-STEP_NEG.
REQ-025 When poz and neg are pressed simultaneously, poz SHALL win.
REQ-026 The Y axis SHALL behave identically with y_off/YMAX; the axes are independent.
REQ-027 Bounce applies per axis only if auto_en is latched 1 and neither button of that axis is pressed.
REQ-028 Bounce moves by AUTO_STEP in direction flag dx/dy: on reaching or passing XMAX, clamp to XMAX and set dx negative; on reaching or passing 0, clamp to 0 and set dx positive.
REQ-029 Bounce SHALL never wrap.
REQ-030 Arithmetic SHALL be 12-bit internally to detect overflow and underflow; outputs SHALL always be within 0..XMAX and 0..YMAX.
REQ-031 If an offset exceeds the limit after a mode change (800->640), APPLY SHALL clamp it to the new max before any move is applied.
REQ-032 With no press and auto_en=0, the offsets SHALL hold their values.

Reset
REQ-033 With rst=0 at a clock edge: x_off=0, y_off=0, upd=0, state=IDLE, dx=dy=positive, debounce counters=0, synchronizers=1, mode_q=mode.
REQ-034 Reset asserted in EVAL or APPLY SHALL abort the update with no upd pulse.
REQ-035 After rst returns to 1, the first frame_tick SHALL be processed normally.

Verification
REQ-036 Hold move_x_poz=0 for 20 cycles, then frame_tick: x_off 0->2 and upd=1 exactly 2 cycles after the tick; y_off stays 0.
REQ-037 Low glitch of 10 cycles on move_x_neg, then frame_tick: x_off unchanged; upd pulses.
REQ-038 mode=0, x_off=590, poz held, tick: x_off=0. x_off=0, neg held, tick: x_off=590.
REQ-039 auto_en=1, no buttons, mode=0, y_off=429, 3 ticks: y_off = 430, 429, 428 (dy flips at 430).
REQ-040 mode=1, x_off=750; switch mode to 0, tick with no buttons: x_off=590; both move_x_poz and move_x_neg held, tick: x_off=0 (poz wins, wrap).
REQ-041 Assert rst=0 the cycle after frame_tick: no upd, offsets=0; release, tick with poz held: x_off=2.
